player_cmd_arbiter: RTL and testbench

PLAYER_CMD_ARBITER -- requirements
Module: player_cmd_arbiter

---
 rtl/player_cmd_arbiter.sv | 104 ++++++++++
 tb/tb_player_cmd_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/player_cmd_arbiter.sv
// Player command arbiter: queues damage/heal events in a 4-deep FIFO and
// issues one player instruction at a time, with FIFO events beating movement.
module player_cmd_arbiter #(
    parameter int unsigned MOVE_GAP = 4,
    parameter logic [7:0]  HEAL_AMT = 8'h0A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmg_req,
    input  logic [7:0]  dmg_amt,
    input  logic        heal_req,
    input  logic        move_req,
    input  logic [1:0]  move_dir,
    output logic [15:0] cmd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        evt_full,
    output logic        evt_drop
);
    localparam logic [3:0] OP_HPY = 4'h1;
    localparam logic [3:0] OP_DPY = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h5;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t     state;
    logic [8:0] fifo [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;
    logic [7:0] cooldown;
    logic       from_fifo;

    logic       pop, wr0, wr1, move_go, drop;
    logic [2:0] cnt_p, cnt_w0, count_nxt;
    logic [8:0] head;

    // Pop frees its slot before the writes are counted; damage claims a slot before heal.
    always_comb begin
        pop       = (state == ISSUE) && cmd_ready && from_fifo;
        cnt_p     = count - 3'(pop);
        wr0       = dmg_req && (cnt_p < 3'd4);
        cnt_w0    = cnt_p + 3'(wr0);
        wr1       = heal_req && (cnt_w0 < 3'd4);
        count_nxt = cnt_w0 + 3'(wr1);
        drop      = (dmg_req && !wr0) || (heal_req && !wr1);
        move_go   = (state == IDLE) && (count == 3'd0) && move_req && (cooldown == 8'd0);
        head      = fifo[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (wr0) fifo[wr_ptr] <= {1'b0, dmg_amt};
        if (wr1) fifo[wr_ptr + 2'(wr0)] <= {1'b1, HEAL_AMT};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            cooldown  <= '0;
            from_fifo <= 1'b0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            evt_full  <= 1'b0;
            evt_drop  <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr + 2'(pop);
            wr_ptr   <= wr_ptr + 2'(wr0) + 2'(wr1);
            count    <= count_nxt;
            evt_full <= (count_nxt == 3'd4);
            evt_drop <= drop;

            if (move_go)
                cooldown <= 8'(MOVE_GAP - 1);
            else if (cooldown != 8'd0)
                cooldown <= cooldown - 8'd1;

            case (state)
                IDLE: begin
                    if (count != 3'd0) begin
                        cmd       <= head[8] ? {OP_HPY, HEAL_AMT, 4'h0} : {OP_DPY, head[7:0], 4'h0};
                        cmd_valid <= 1'b1;
                        from_fifo <= 1'b1;
                        state     <= ISSUE;
                    end else if (move_go) begin
                        cmd       <= {OP_MOV, 6'b0, move_dir, 4'h0};
                        cmd_valid <= 1'b1;
                        from_fifo <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd       <= '0;
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_player_cmd_arbiter.sv
// Bench for player_cmd_arbiter: directed vector table, then random traffic
// checked against a queue-based model of the event/command rules.
module tb_player_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, dmg_req, heal_req, move_req, cmd_ready;
    logic [7:0]  dmg_amt;
    logic [1:0]  move_dir;
    logic [15:0] cmd;
    logic        cmd_valid, evt_full, evt_drop;

    int n_cmp = 0;
    int n_err = 0;

    player_cmd_arbiter #(.MOVE_GAP(4), .HEAL_AMT(8'h0A)) dut (
        .clk(clk), .rst_n(rst_n), .dmg_req(dmg_req), .dmg_amt(dmg_amt),
        .heal_req(heal_req), .move_req(move_req), .move_dir(move_dir),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .evt_full(evt_full), .evt_drop(evt_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, dmg;
        logic [7:0]  amt;
        logic        heal, mv;
        logic [1:0]  dir;
        logic        rdy;
        logic [15:0] cmd;
        logic        vld, full, drop;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic d, logic [7:0] a, logic h, logic m,
                                logic [1:0] dr, logic rd, logic [15:0] c,
                                logic v, logic f, logic dp);
        vec_t t;
        t.rst_n = r; t.dmg = d; t.amt = a; t.heal = h; t.mv = m; t.dir = dr; t.rdy = rd;
        t.cmd = c; t.vld = v; t.full = f; t.drop = dp;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: queue of {kind, amount}, in-flight command, cooldown.
    logic [8:0]  mq[$];
    logic        m_busy, m_fifo, m_drop, m_full;
    logic [15:0] m_cmd;
    int          m_cd;

    task automatic model_step();
        int old_n;
        logic [8:0] hd;
        logic ld_mv;
        if (!rst_n) begin
            mq.delete(); m_busy = 0; m_fifo = 0; m_cmd = 0; m_cd = 0; m_drop = 0; m_full = 0;
            return;
        end
        old_n = mq.size();
        hd = (old_n > 0) ? mq[0] : 9'h0;
        ld_mv = 0;
        if (m_busy) begin
            if (cmd_ready) begin
                if (m_fifo) void'(mq.pop_front());
                m_busy = 0; m_cmd = 0;
            end
        end else if (old_n > 0) begin
            m_cmd = hd[8] ? {4'h1, 8'h0A, 4'h0} : {4'h2, hd[7:0], 4'h0};
            m_busy = 1; m_fifo = 1;
        end else if (move_req && m_cd == 0) begin
            m_cmd = {4'h5, 6'b0, move_dir, 4'h0};
            m_busy = 1; m_fifo = 0; ld_mv = 1;
        end
        m_drop = 0;
        if (dmg_req)  begin if (mq.size() < 4) mq.push_back({1'b0, dmg_amt}); else m_drop = 1; end
        if (heal_req) begin if (mq.size() < 4) mq.push_back({1'b1, 8'h00});  else m_drop = 1; end
        m_cd = ld_mv ? 3 : (m_cd > 0 ? m_cd - 1 : 0);
        m_full = (mq.size() == 4);
    endtask

    initial begin
        rst_n = 0; dmg_req = 0; dmg_amt = 0; heal_req = 0; move_req = 0; move_dir = 0; cmd_ready = 0;

        //            rst dmg amt   heal mv dir rdy  cmd       v f d
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        // single damage event
        tv.push_back(mk(1, 1, 8'h07, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h2070, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        // damage + heal in one cycle
        tv.push_back(mk(1, 1, 8'h03, 1, 0, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h2030, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h10A0, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        // six damages with the datapath stalled: fill, then drops
        tv.push_back(mk(1, 1, 8'h01, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 1, 8'h02, 0, 0, 0, 0, 16'h2010, 1, 0, 0));
        tv.push_back(mk(1, 1, 8'h03, 0, 0, 0, 0, 16'h2010, 1, 0, 0));
        tv.push_back(mk(1, 1, 8'h04, 0, 0, 0, 0, 16'h2010, 1, 1, 0));
        tv.push_back(mk(1, 1, 8'h05, 0, 0, 0, 0, 16'h2010, 1, 1, 1));
        tv.push_back(mk(1, 1, 8'h06, 0, 0, 0, 0, 16'h2010, 1, 1, 1));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 16'h2010, 1, 1, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h2020, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 1, 8'h07, 0, 0, 0, 0, 16'h2030, 1, 0, 0));
        // reset while issuing with three queued events
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        // held move, gap of 4
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h5030, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h5030, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h0000, 0, 0, 0));
        // damage interleaved with held move
        tv.push_back(mk(1, 1, 8'h09, 0, 1, 3, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h2090, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 1, 3, 1, 16'h5030, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 0, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst_n = tv[i].rst_n; dmg_req = tv[i].dmg; dmg_amt = tv[i].amt; heal_req = tv[i].heal;
            move_req = tv[i].mv; move_dir = tv[i].dir; cmd_ready = tv[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d cmd", i),  cmd, tv[i].cmd);
            chk($sformatf("vec%0d vld", i),  16'(cmd_valid), 16'(tv[i].vld));
            chk($sformatf("vec%0d full", i), 16'(evt_full),  16'(tv[i].full));
            chk($sformatf("vec%0d drop", i), 16'(evt_drop),  16'(tv[i].drop));
        end

        // Random traffic against the model, starting from a reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n     = (c < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
            dmg_req   = ($urandom_range(0, 9) < 3);
            dmg_amt   = 8'($urandom);
            heal_req  = ($urandom_range(0, 9) < 2);
            move_req  = ($urandom_range(0, 1) == 1);
            move_dir  = 2'($urandom);
            cmd_ready = ($urandom_range(0, 9) < 5);
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rnd%0d cmd", c),  cmd, m_cmd);
            chk($sformatf("rnd%0d vld", c),  16'(cmd_valid), 16'(m_busy));
            chk($sformatf("rnd%0d full", c), 16'(evt_full),  16'(m_full));
            chk($sformatf("rnd%0d drop", c), 16'(evt_drop),  16'(m_drop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
